store_align: RTL and testbench

STORE_ALIGN -- requirements
Module: store_align

---
 rtl/store_align.sv | 216 +++++++++++++++++++++
 tb/tb_store_align.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_align.sv
// store_align: splits byte/halfword/word stores into lane-positioned,
// word-aligned memory beats (one beat, or two when a store crosses a word).
// Optional feature macro: MISALIGN_SPLIT_EN. When it is defined, misaligned
// stores become two beats. Otherwise they raise MISALIGN_EXC_CODE and issue
// no beat.
//
// Handshakes (valid/ready):
// - A request transfers on a cycle with req_valid && req_ready && clk_en && !halt.
// - A memory beat transfers on a cycle with mem_valid && mem_ready.
// - mem_valid already includes the stall and reset gating, so nothing else is needed.
// - While a beat is offered and not taken, mem_addr/mem_we/mem_wdata hold.
module store_align #(
  parameter logic [7:0] MISALIGN_EXC_CODE = 8'h82
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        halt,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  opcode,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  output logic        misaligned,
  output logic        done,
  output logic        exc_valid,
  output logic [7:0]  exc_code,
  output logic [1:0]  dbg_state
);

`ifdef MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1, BEAT1 = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [4:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        mem_valid_q, mem_valid_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_we_q, mem_we_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        misaligned_q, misaligned_d;
  logic        done_q, done_d;
  logic        exc_q, exc_d;
  logic [7:0]  exc_code_q, exc_code_d;

  logic        adv, fire, last_beat;
  logic [4:0]  src_op;
  logic [31:0] src_addr, src_data;
  logic        op_ok, two_beat;
  logic [3:0]  mask, we0, we1;
  logic [7:0]  we_wide;
  logic [1:0]  k;
  logic [2:0]  shamt1;
  logic [31:0] dmask, wd0, wd1;

  assign adv       = clk_en && !halt;
  assign mem_valid = mem_valid_q && adv && !rst;
  assign fire      = mem_valid && mem_ready;
  // Single-beat stores finish in BEAT0; split stores finish in BEAT1.
  assign last_beat = (state_q == BEAT1) || !misaligned_q;
  assign done      = adv && !rst && (done_q || (fire && last_beat));
  assign exc_valid = adv && !rst && exc_q;
  assign req_ready = (state_q == IDLE);
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign misaligned = misaligned_q;
  assign exc_code  = exc_code_q;
  assign dbg_state = state_q;

  // Lane math for both beats, taken from the live request in IDLE and from
  // the captured request afterwards.
  always_comb begin
    src_op   = op_q;
    src_addr = addr_q;
    src_data = data_q;
    if (state_q == IDLE) begin
      src_op   = opcode;
      src_addr = addr;
      src_data = data;
    end
    op_ok = 1'b1;
    mask  = 4'b0000;
    dmask = 32'h0;
    if (src_op >= 5'd3 && src_op <= 5'd5) begin
      mask  = 4'b1111;
      dmask = src_data;
    end else if (src_op >= 5'd6 && src_op <= 5'd8) begin
      mask  = 4'b0011;
      dmask = {16'h0, src_data[15:0]};
    end else if (src_op >= 5'd9 && src_op <= 5'd11) begin
      mask  = 4'b0001;
      dmask = {24'h0, src_data[7:0]};
    end else begin
      op_ok = 1'b0;
    end
    k        = src_addr[1:0];
    we_wide  = {4'b0000, mask} << k;
    we0      = we_wide[3:0];
    two_beat = |we_wide[7:4];
    shamt1   = 3'd4 - {1'b0, k};
    we1      = mask >> shamt1;
    wd0      = dmask << {k, 3'b000};
    wd1      = dmask >> {shamt1, 3'b000};
  end

  // Next-state and registered-output logic; everything holds while stalled.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    data_d       = data_q;
    mem_valid_d  = mem_valid_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = mem_we_q;
    mem_wdata_d  = mem_wdata_q;
    misaligned_d = misaligned_q;
    done_d       = done_q;
    exc_d        = exc_q;
    exc_code_d   = exc_code_q;
    if (adv) begin
      done_d = 1'b0;
      exc_d  = 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            op_d   = opcode;
            addr_d = addr;
            data_d = data;
            if (!op_ok) begin
              done_d = 1'b1;
            end else if (two_beat && !SPLIT_EN) begin
              done_d     = 1'b1;
              exc_d      = 1'b1;
              exc_code_d = MISALIGN_EXC_CODE;
            end else begin
              state_d      = BEAT0;
              mem_valid_d  = 1'b1;
              mem_addr_d   = {src_addr[31:2], 2'b00};
              mem_we_d     = we0;
              mem_wdata_d  = wd0;
              misaligned_d = two_beat;
            end
          end
        end
        BEAT0: begin
          if (fire) begin
            if (misaligned_q) begin
              state_d     = BEAT1;
              mem_addr_d  = mem_addr_q + 32'd4;
              mem_we_d    = we1;
              mem_wdata_d = wd1;
            end else begin
              state_d     = IDLE;
              mem_valid_d = 1'b0;
            end
          end
        end
        BEAT1: begin
          if (fire) begin
            state_d      = IDLE;
            mem_valid_d  = 1'b0;
            misaligned_d = 1'b0;
          end
        end
        default: begin
          state_d     = IDLE;
          mem_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State registers; reset wins over any stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= 5'd0;
      addr_q       <= 32'h0;
      data_q       <= 32'h0;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_we_q     <= 4'h0;
      mem_wdata_q  <= 32'h0;
      misaligned_q <= 1'b0;
      done_q       <= 1'b0;
      exc_q        <= 1'b0;
      exc_code_q   <= 8'h00;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      mem_valid_q  <= mem_valid_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      misaligned_q <= misaligned_d;
      done_q       <= done_d;
      exc_q        <= exc_d;
      exc_code_q   <= exc_code_d;
    end
  end

endmodule

// File: tb/tb_store_align.sv
// tb_store_align: directed bench for store_align (default build or with
// MISALIGN_SPLIT_EN defined).
module tb_store_align;

  logic        clk = 1'b0;
  logic        rst, clk_en, halt, req_valid, mem_ready;
  logic [4:0]  opcode;
  logic [31:0] addr, data;
  logic        req_ready, mem_valid, misaligned, done, exc_valid;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_we;
  logic [7:0]  exc_code;
  logic [1:0]  dbg_state;

  int n_chk = 0;
  int n_fail = 0;
  int beat_cnt = 0;
  int done_cnt = 0;
  int acc_cnt = 0;
  logic [67:0] exp_q[$];
  logic [67:0] mon_exp;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] d;
    logic        beat;
    logic [31:0] ea;
    logic [3:0]  we;
    logic [31:0] wd;
  } vec_t;
  vec_t vt[12];

  // clock / reset
  always #5 clk = ~clk;

  store_align dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .halt(halt),
    .req_valid(req_valid), .req_ready(req_ready),
    .opcode(opcode), .addr(addr), .data(data),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .misaligned(misaligned), .done(done),
    .exc_valid(exc_valid), .exc_code(exc_code), .dbg_state(dbg_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_req(input logic [4:0] op, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    opcode    = op;
    addr      = a;
    data      = d;
  endtask

  // scoreboard: every completed beat must match the head of exp_q
  always @(negedge clk) begin
    if (mem_valid && mem_ready) begin
      beat_cnt++;
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL beat_unexpected: got %h/%b/%h expected no beat", mem_addr, mem_we, mem_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({mem_addr, mem_we, mem_wdata} !== mon_exp) begin
          n_fail++;
          $display("FAIL beat_data: got %h expected %h", {mem_addr, mem_we, mem_wdata}, mon_exp);
        end
      end
    end
    if (done) done_cnt++;
    if (req_valid && req_ready && clk_en && !halt && !rst) acc_cnt++;
  end

  // misaligned word/halfword: two beats when split, exception otherwise
  task automatic mis_seq(input string nm, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] d,
                         input logic [31:0] a0, input logic [3:0] we0, input logic [31:0] wd0,
                         input logic [31:0] a1, input logic [3:0] we1, input logic [31:0] wd1);
    int d0;
    d0 = done_cnt;
    mem_ready = 1'b1;
    drive_req(op, a, d);
    settle();
    chk({nm, "_ready"}, 32'(req_ready), 32'h1);
`ifdef MISALIGN_SPLIT_EN
    exp_q.push_back({a0, we0, wd0});
    exp_q.push_back({a1, we1, wd1});
    cyc();
    req_valid = 1'b0;
    settle();
    chk({nm, "_b0_valid"}, 32'(mem_valid), 32'h1);
    chk({nm, "_b0_addr"}, mem_addr, a0);
    chk({nm, "_b0_we"}, 32'(mem_we), 32'(we0));
    chk({nm, "_b0_wdata"}, mem_wdata, wd0);
    chk({nm, "_b0_mis"}, 32'(misaligned), 32'h1);
    chk({nm, "_b0_done"}, 32'(done), 32'h0);
    cyc();
    settle();
    chk({nm, "_b1_addr"}, mem_addr, a1);
    chk({nm, "_b1_we"}, 32'(mem_we), 32'(we1));
    chk({nm, "_b1_wdata"}, mem_wdata, wd1);
    chk({nm, "_b1_mis"}, 32'(misaligned), 32'h1);
    chk({nm, "_b1_done"}, 32'(done), 32'h1);
    chk({nm, "_b1_exc"}, 32'(exc_valid), 32'h0);
    cyc();
    settle();
    chk({nm, "_end_mis"}, 32'(misaligned), 32'h0);
`else
    cyc();
    req_valid = 1'b0;
    settle();
    chk({nm, "_valid"}, 32'(mem_valid), 32'h0);
    chk({nm, "_exc"}, 32'(exc_valid), 32'h1);
    chk({nm, "_code"}, 32'(exc_code), 32'h82);
    chk({nm, "_done"}, 32'(done), 32'h1);
    chk({nm, "_mis"}, 32'(misaligned), 32'h0);
    cyc();
    settle();
    chk({nm, "_exc_clr"}, 32'(exc_valid), 32'h0);
`endif
    chk({nm, "_ready_back"}, 32'(req_ready), 32'h1);
    chk({nm, "_done_clr"}, 32'(done), 32'h0);
    chk({nm, "_done_cnt"}, 32'(done_cnt - d0), 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1);
  end

  initial begin
    int d0, b0, a0;
    vt[0]  = '{5'd9,  32'h0000_0102, 32'h0000_00AB, 1'b1, 32'h0000_0100, 4'b0100, 32'h00AB_0000};
    vt[1]  = '{5'd10, 32'h0000_1003, 32'h1234_5678, 1'b1, 32'h0000_1000, 4'b1000, 32'h7800_0000};
    vt[2]  = '{5'd11, 32'h0000_0000, 32'hCAFE_00C3, 1'b1, 32'h0000_0000, 4'b0001, 32'h0000_00C3};
    vt[3]  = '{5'd9,  32'h0000_0005, 32'h0000_0099, 1'b1, 32'h0000_0004, 4'b0010, 32'h0000_9900};
    vt[4]  = '{5'd6,  32'h0000_2000, 32'hDEAD_BEEF, 1'b1, 32'h0000_2000, 4'b0011, 32'h0000_BEEF};
    vt[5]  = '{5'd7,  32'h0000_2001, 32'h0000_1234, 1'b1, 32'h0000_2000, 4'b0110, 32'h0012_3400};
    vt[6]  = '{5'd8,  32'h0000_2002, 32'hFFFF_5A5A, 1'b1, 32'h0000_2000, 4'b1100, 32'h5A5A_0000};
    vt[7]  = '{5'd3,  32'h0000_3000, 32'h1122_3344, 1'b1, 32'h0000_3000, 4'b1111, 32'h1122_3344};
    vt[8]  = '{5'd5,  32'hFFFF_FFFC, 32'hA5A5_A5A5, 1'b1, 32'hFFFF_FFFC, 4'b1111, 32'hA5A5_A5A5};
    vt[9]  = '{5'd0,  32'h0000_0040, 32'h1111_1111, 1'b0, 32'h0,         4'b0000, 32'h0};
    vt[10] = '{5'd12, 32'h0000_0041, 32'h2222_2222, 1'b0, 32'h0,         4'b0000, 32'h0};
    vt[11] = '{5'd31, 32'h0000_0043, 32'h3333_3333, 1'b0, 32'h0,         4'b0000, 32'h0};

    rst = 1'b1; clk_en = 1'b1; halt = 1'b0; req_valid = 1'b0; mem_ready = 1'b0;
    opcode = 5'd0; addr = 32'h0; data = 32'h0;
    repeat (2) cyc();
    rst = 1'b0;
    settle();

    // reset state
    chk("rst_state", 32'(dbg_state), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h1);
    chk("rst_mem_valid", 32'(mem_valid), 32'h0);
    chk("rst_mis", 32'(misaligned), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_exc", 32'(exc_valid), 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_we", 32'(mem_we), 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_code", 32'(exc_code), 32'h0);

    // single-beat and no-beat vectors
    mem_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive_req(vt[i].op, vt[i].a, vt[i].d);
      settle();
      chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'h1);
      if (vt[i].beat) exp_q.push_back({vt[i].ea, vt[i].we, vt[i].wd});
      cyc();
      req_valid = 1'b0;
      settle();
      chk($sformatf("v%0d_valid", i), 32'(mem_valid), 32'(vt[i].beat));
      chk($sformatf("v%0d_done", i), 32'(done), 32'h1);
      chk($sformatf("v%0d_exc", i), 32'(exc_valid), 32'h0);
      if (vt[i].beat) begin
        chk($sformatf("v%0d_addr", i), mem_addr, vt[i].ea);
        chk($sformatf("v%0d_we", i), 32'(mem_we), 32'(vt[i].we));
        chk($sformatf("v%0d_wdata", i), mem_wdata, vt[i].wd);
        chk($sformatf("v%0d_mis", i), 32'(misaligned), 32'h0);
      end
      cyc();
      settle();
      chk($sformatf("v%0d_ready_back", i), 32'(req_ready), 32'h1);
      chk($sformatf("v%0d_done_clr", i), 32'(done), 32'h0);
    end

    // misaligned stores
    mis_seq("w201", 5'd4, 32'h0000_0201, 32'h1122_3344,
            32'h0000_0200, 4'b1110, 32'h2233_4400, 32'h0000_0204, 4'b0001, 32'h0000_0011);
    mis_seq("hwrap", 5'd7, 32'hFFFF_FFFF, 32'h0000_BEEF,
            32'hFFFF_FFFC, 4'b1000, 32'hEF00_0000, 32'h0000_0000, 4'b0001, 32'h0000_00BE);
    mis_seq("w402", 5'd3, 32'h0000_0402, 32'hA1B2_C3D4,
            32'h0000_0400, 4'b1100, 32'hC3D4_0000, 32'h0000_0404, 4'b0011, 32'h0000_A1B2);
    mis_seq("w007", 5'd5, 32'h0000_0007, 32'h0102_0304,
            32'h0000_0004, 4'b1000, 32'h0400_0000, 32'h0000_0008, 4'b0111, 32'h0001_0203);

    // backpressure then halt and clk_en stalls on an aligned word
    b0 = beat_cnt; d0 = done_cnt;
    mem_ready = 1'b0;
    drive_req(5'd3, 32'h0000_0300, 32'hCAFE_BABE);
    exp_q.push_back({32'h0000_0300, 4'b1111, 32'hCAFE_BABE});
    cyc();
    req_valid = 1'b0;
    settle();
    chk("bp_valid", 32'(mem_valid), 32'h1);
    for (int j = 0; j < 2; j++) begin
      cyc();
      settle();
      chk($sformatf("bp%0d_valid", j), 32'(mem_valid), 32'h1);
      chk($sformatf("bp%0d_addr", j), mem_addr, 32'h0000_0300);
      chk($sformatf("bp%0d_we", j), 32'(mem_we), 32'hF);
      chk($sformatf("bp%0d_wdata", j), mem_wdata, 32'hCAFE_BABE);
      chk($sformatf("bp%0d_done", j), 32'(done), 32'h0);
    end
    cyc();
    halt = 1'b1; mem_ready = 1'b1;
    settle();
    chk("halt_valid", 32'(mem_valid), 32'h0);
    chk("halt_done", 32'(done), 32'h0);
    chk("halt_state", 32'(dbg_state), 32'h1);
    chk("halt_wdata", mem_wdata, 32'hCAFE_BABE);
    cyc();
    halt = 1'b0; clk_en = 1'b0;
    settle();
    chk("clken_valid", 32'(mem_valid), 32'h0);
    chk("clken_done", 32'(done), 32'h0);
    chk("clken_ready", 32'(req_ready), 32'h0);
    cyc();
    clk_en = 1'b1;
    settle();
    chk("resume_valid", 32'(mem_valid), 32'h1);
    chk("resume_done", 32'(done), 32'h1);
    chk("resume_addr", mem_addr, 32'h0000_0300);
    cyc();
    settle();
    chk("stall_ready_back", 32'(req_ready), 32'h1);
    chk("stall_beats", 32'(beat_cnt - b0), 32'h1);
    chk("stall_dones", 32'(done_cnt - d0), 32'h1);

    // reset while a beat is in flight, with halt also asserted
    d0 = done_cnt;
    mem_ready = 1'b1;
`ifdef MISALIGN_SPLIT_EN
    drive_req(5'd3, 32'h0000_0201, 32'h1122_3344);
    exp_q.push_back({32'h0000_0200, 4'b1110, 32'h2233_4400});
    cyc();
    req_valid = 1'b0;
    cyc();
    rst = 1'b1; halt = 1'b1;
    settle();
    chk("rstb_state", 32'(dbg_state), 32'h2);
`else
    drive_req(5'd3, 32'h0000_0500, 32'h5555_AAAA);
    cyc();
    req_valid = 1'b0;
    rst = 1'b1; halt = 1'b1;
    settle();
    chk("rstb_state", 32'(dbg_state), 32'h1);
`endif
    chk("rstb_valid", 32'(mem_valid), 32'h0);
    chk("rstb_done", 32'(done), 32'h0);
    cyc();
    rst = 1'b0; halt = 1'b0;
    settle();
    chk("rsta_state", 32'(dbg_state), 32'h0);
    chk("rsta_valid", 32'(mem_valid), 32'h0);
    chk("rsta_ready", 32'(req_ready), 32'h1);
    chk("rsta_mis", 32'(misaligned), 32'h0);
    chk("rsta_addr", mem_addr, 32'h0);
    chk("rsta_we", 32'(mem_we), 32'h0);
    chk("rsta_done_cnt", 32'(done_cnt - d0), 32'h0);

    // back-to-back aligned throughput: one store every 2 cycles
    d0 = done_cnt; a0 = acc_cnt;
    mem_ready = 1'b1;
    drive_req(5'd9, 32'h0000_0010, 32'h0000_005A);
    for (int j = 0; j < 3; j++) exp_q.push_back({32'h0000_0010, 4'b0001, 32'h0000_005A});
    repeat (6) cyc();
    req_valid = 1'b0;
    settle();
    chk("tp_accepts", 32'(acc_cnt - a0), 32'h3);
    chk("tp_dones", 32'(done_cnt - d0), 32'h3);

`ifdef MISALIGN_SPLIT_EN
    // back-to-back misaligned throughput: one store every 3 cycles
    d0 = done_cnt; a0 = acc_cnt;
    drive_req(5'd3, 32'h0000_0201, 32'h1122_3344);
    for (int j = 0; j < 2; j++) begin
      exp_q.push_back({32'h0000_0200, 4'b1110, 32'h2233_4400});
      exp_q.push_back({32'h0000_0204, 4'b0001, 32'h0000_0011});
    end
    repeat (6) cyc();
    req_valid = 1'b0;
    settle();
    chk("tpm_accepts", 32'(acc_cnt - a0), 32'h2);
    chk("tpm_dones", 32'(done_cnt - d0), 32'h2);
`endif

    cyc();
    settle();
    chk("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
